home_slot_tracker: RTL

//  Parametrised frog home-slot tracker for the goal row. Latches arrival of the frog at any of
//  NUM_HOMES home columns, drives the goal-row display bus, and flags duplicate and missed landings.

---
 rtl/home_slot_tracker_pkg.sv | 25 ++
 rtl/home_slot_tracker_if.sv | 32 +++
 rtl/home_slot_tracker_match.sv | 24 ++
 rtl/home_slot_tracker.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/home_slot_tracker_pkg.sv
// Shared types and defaults for the goal-row home-slot tracker: FSM state encoding,
// default home layout and the column-to-bus-bit mapping.
package home_slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int               DEF_NUM_HOMES  = 3;
    localparam int               DEF_POS_W      = 3;
    localparam int               DEF_ESTADO_W   = 3;
    localparam int               DEF_BUS_W      = 8;
    localparam int               DEF_LEVEL_W    = 4;
    localparam logic [2:0]       DEF_GOAL_ROW   = 3'b111;
    localparam logic [2:0]       DEF_PLAY_STATE = 3'b111;
    localparam logic [3*3-1:0]   DEF_HOME_X_VEC = {3'd6, 3'd4, 3'd1};

    // Column x is drawn on bus bit bus_w-1-x (leftmost column is the MSB).
    function automatic int col2bit(input int x, input int bus_w = DEF_BUS_W);
        return bus_w - 1 - x;
    endfunction

endpackage

// File: rtl/home_slot_tracker_if.sv
// Bus between the game FSM/position registers (master) and the home-slot tracker (slave).
interface home_slot_tracker_if
    import home_slot_pkg::*;
#(
    parameter int NUM_HOMES = DEF_NUM_HOMES,
    parameter int POS_W     = DEF_POS_W,
    parameter int ESTADO_W  = DEF_ESTADO_W,
    parameter int BUS_W     = DEF_BUS_W,
    parameter int LEVEL_W   = DEF_LEVEL_W
);
    logic [POS_W-1:0]     posx;
    logic [POS_W-1:0]     posy;
    logic [ESTADO_W-1:0]  estado;
    logic                 perdio;

    logic [BUS_W-1:0]     row;
    logic [NUM_HOMES-1:0] occ;
    logic                 level_done;
    logic                 dup;
    logic                 miss;
    logic [LEVEL_W-1:0]   level;

    modport master (
        output posx, posy, estado, perdio,
        input  row, occ, level_done, dup, miss, level
    );

    modport slave (
        input  posx, posy, estado, perdio,
        output row, occ, level_done, dup, miss, level
    );
endinterface

// File: rtl/home_slot_tracker_match.sv
// Combinational comparison of the frog X against every home column.
module home_slot_match
    import home_slot_pkg::*;
#(
    parameter int NUM_HOMES = DEF_NUM_HOMES,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic [POS_W-1:0]           x,
    input  logic [NUM_HOMES*POS_W-1:0] home_x_vec,
    output logic [NUM_HOMES-1:0]       hit,
    output logic                       any_hit
);

    // Home columns are unique, so at most one bit of hit is set.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_HOMES; i++) begin
            hit[i] = (home_x_vec[i*POS_W +: POS_W] == x);
        end
    end

    assign any_hit = |hit;

endmodule

// File: rtl/home_slot_tracker.sv
// Goal-row home-slot tracker: FSM, occupancy, event pulses, level counter and display row.
// Optional build macro CC_HOME_BLINK_EN makes the newest-filled home blink on the display.
module home_slot_tracker
    import home_slot_pkg::*;
#(
    parameter int                         NUM_HOMES  = DEF_NUM_HOMES,
    parameter int                         POS_W      = DEF_POS_W,
    parameter int                         ESTADO_W   = DEF_ESTADO_W,
    parameter int                         BUS_W      = DEF_BUS_W,
    parameter logic [POS_W-1:0]           GOAL_ROW   = DEF_GOAL_ROW,
    parameter logic [ESTADO_W-1:0]        PLAY_STATE = DEF_PLAY_STATE,
    parameter logic [NUM_HOMES*POS_W-1:0] HOME_X_VEC = DEF_HOME_X_VEC,
    parameter int                         LEVEL_W    = DEF_LEVEL_W,
    parameter int                         BLINK_DIV  = 24
) (
    input logic               CC_CLOCK_50,
    input logic               CC_RESET,
    home_slot_tracker_if.slave bus
);

    localparam logic [NUM_HOMES-1:0] ALL_FILLED = '1;

    if (NUM_HOMES < 1 || NUM_HOMES > BUS_W || BLINK_DIV < 1) begin : g_bad_param
        $error("home_slot_tracker: illegal parameter combination");
    end

    state_t               state_q, state_n;
    logic [NUM_HOMES-1:0] occ_q, occ_n;
    logic [NUM_HOMES-1:0] occ_disp;
    logic [LEVEL_W-1:0]   level_q;
    logic                 at_goal_q;
    logic                 done_q, dup_q, miss_q;
    logic                 done_n, dup_n, miss_n;
    logic [BUS_W-1:0]     row_n;

    logic                 play;
    logic                 at_goal;
    logic                 arrive;
    logic [NUM_HOMES-1:0] hit;
    logic                 any_hit;

    assign play    = (bus.estado == PLAY_STATE);
    assign at_goal = (bus.posy == GOAL_ROW);
    // Edge-detect on the goal row so a frog parked there is counted once.
    assign arrive  = play & at_goal & ~at_goal_q;

    home_slot_match #(
        .NUM_HOMES (NUM_HOMES),
        .POS_W     (POS_W)
    ) u_match (
        .x          (bus.posx),
        .home_x_vec (HOME_X_VEC),
        .hit        (hit),
        .any_hit    (any_hit)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_n = state_q;
        occ_n   = occ_q;
        done_n  = 1'b0;
        dup_n   = 1'b0;
        miss_n  = 1'b0;

        if (bus.perdio) begin
            occ_n   = '0;
            state_n = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (play) state_n = ST_ARMED;
                end
                ST_ARMED: begin
                    if (!play) begin
                        state_n = ST_IDLE;
                    end else if (arrive) begin
                        if (!any_hit) begin
                            miss_n = 1'b1;
                        end else if ((hit & occ_q) != '0) begin
                            dup_n = 1'b1;
                        end else begin
                            occ_n = occ_q | hit;
                            if (occ_n == ALL_FILLED) begin
                                state_n = ST_FULL;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                ST_FULL: begin
                    if (!at_goal) begin
                        occ_n   = '0;
                        state_n = play ? ST_ARMED : ST_IDLE;
                    end
                end
                default: begin
                    occ_n   = '0;
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CC_CLOCK_50 or posedge CC_RESET) begin
        if (CC_RESET) begin
            state_q   <= ST_IDLE;
            occ_q     <= '0;
            level_q   <= '0;
            at_goal_q <= 1'b0;
            done_q    <= 1'b0;
            dup_q     <= 1'b0;
            miss_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            occ_q     <= occ_n;
            at_goal_q <= at_goal;
            done_q    <= done_n;
            dup_q     <= dup_n;
            miss_q    <= miss_n;
            if (done_n) level_q <= level_q + LEVEL_W'(1);
        end
    end

`ifdef CC_HOME_BLINK_EN
    logic [NUM_HOMES-1:0] newest_q;
    logic [BLINK_DIV-1:0] blink_cnt_q;
    logic                 blink_q;
    logic [NUM_HOMES-1:0] new_fill;

    assign new_fill = occ_n & ~occ_q;

    // The blink phase restarts on each fill; clearing occupancy also stops the blink.
    always_ff @(posedge CC_CLOCK_50 or posedge CC_RESET) begin
        if (CC_RESET) begin
            newest_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (new_fill != '0) begin
            newest_q    <= new_fill;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            if (occ_n == '0) newest_q <= '0;
            blink_cnt_q <= blink_cnt_q + BLINK_DIV'(1);
            if (&blink_cnt_q) blink_q <= ~blink_q;
        end
    end

    assign occ_disp = occ_q & ~(newest_q & {NUM_HOMES{blink_q}});
`else
    assign occ_disp = occ_q;
`endif

    // Homes whose column falls off the bus never match any bit and are not drawn.
    always_comb begin
        row_n = '1;
        for (int b = 0; b < BUS_W; b++) begin
            for (int i = 0; i < NUM_HOMES; i++) begin
                if (col2bit(int'(HOME_X_VEC[i*POS_W +: POS_W]), BUS_W) == b) row_n[b] = occ_disp[i];
            end
        end
    end

    assign bus.row        = row_n;
    assign bus.occ        = occ_q;
    assign bus.level_done = done_q;
    assign bus.dup        = dup_q;
    assign bus.miss       = miss_q;
    assign bus.level      = level_q;

endmodule
